// File: rtl/arb_pkg.sv
// Shared types and constants for the round-robin encoder arbiter.
package arb_pkg;
  localparam int N     = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  function automatic logic [N-1:0] onehot(input logic [IDX_W-1:0] i);
    logic [N-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction
endpackage

// File: rtl/rr_enc_arbiter_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
interface rr_enc_arbiter_if;
  import arb_pkg::*;

  logic             en;
  logic [N-1:0]     req;
  logic             done;
  logic [N-1:0]     gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_vld;
  logic             timeout;

  modport master (
    output en, req, done,
    input  gnt, gnt_idx, gnt_vld, timeout
  );

  modport slave (
    input  en, req, done,
    output gnt, gnt_idx, gnt_vld, timeout
  );
endinterface

// File: rtl/rr_prio_enc.sv
// Rotated 8->3 priority encoder: lowest set bit at or above ptr wins, wrapping.
module rr_prio_enc
  import arb_pkg::*;
(
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [N-1:0]     rot;
  logic [IDX_W-1:0] enc;

  // rot[0] is the requester sitting at the current pointer
  generate
    for (genvar g = 0; g < N; g++) begin : g_rot
      logic [IDX_W-1:0] src;
      assign src    = IDX_W'(g) + ptr;
      assign rot[g] = req[src];
    end
  endgenerate

  always_comb begin
    enc = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) enc = IDX_W'(i);
    end
  end

  assign idx = enc + ptr;
  assign any = |req;

endmodule

// File: rtl/rr_enc_arbiter.sv
// Round-robin arbiter for 8 requesters; grant held until done, request drop
// or hold limit, with a one-cycle timeout pulse on hold-limit revocation.
module rr_enc_arbiter
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  rr_enc_arbiter_if.slave  bus
);

  localparam int CNT_W = $clog2(MAX_HOLD);

  state_e           state_q, state_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tmo_q, tmo_d;

  logic [IDX_W-1:0] win;
  logic             any;
  logic             hold_lim;
  logic             req_held;

  rr_prio_enc u_enc (
    .req (bus.req),
    .ptr (ptr_q),
    .idx (win),
    .any (any)
  );

  assign hold_lim = (cnt_q == CNT_W'(MAX_HOLD - 1));
  assign req_held = bus.req[idx_q];

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    tmo_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.en && any) begin
          state_d = GRANT;
          gnt_d   = onehot(win);
          idx_d   = win;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (bus.done || !req_held || hold_lim) begin
          state_d = IDLE;
          gnt_d   = '0;
          idx_d   = '0;
          cnt_d   = '0;
          ptr_d   = idx_q + IDX_W'(1);
          // a normal release (done or drop) masks the hold limit
          tmo_d   = hold_lim && !bus.done && req_held;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.gnt_idx = idx_q;
  assign bus.gnt_vld = (state_q == GRANT);
  assign bus.timeout = tmo_q;

endmodule
